// File: rtl/nand_gate_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nand_gate_pkg
// Description : Shared defaults and reset constant for the NAND gate block.
// Revision    : 1.0 - initial release
// ============================================================================
package nand_gate_pkg;

    // Default operand width
    localparam int DEFAULT_WIDTH = 1;

    // Default change-counter width
    localparam int DEFAULT_CNT_W = 16;

    // Reset value of y_q: NAND of all-zero operands, i.e. all ones.
    // Sized to the widest legal operand and sliced down by the user.
    localparam logic [63:0] Y_Q_RST_VAL = '1;

endpackage : nand_gate_pkg
`default_nettype wire

// File: rtl/nand_gate_core.sv
`default_nettype none
// ============================================================================
// Module      : nand_gate_core
// Description : Purely combinational bitwise NAND of two operands.
// Revision    : 1.0 - initial release
// ============================================================================
module nand_gate_core #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // Bitwise NAND; a 0 on either operand bit forces that result bit high
    assign y = ~(a & b);

endmodule : nand_gate_core
`default_nettype wire

// File: rtl/nand_gate.sv
`default_nettype none
// ============================================================================
// Module      : nand_gate
// Description : Bitwise NAND with a registered copy of the result and a
//               saturating counter of clock edges on which the registered
//               result changed.
// Revision    : 1.0 - initial release
// ============================================================================
module nand_gate
    import nand_gate_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic [CNT_W-1:0] chg_cnt
);

    localparam logic [WIDTH-1:0] Y_Q_RST = Y_Q_RST_VAL[WIDTH-1:0];
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] y_q_d;
    logic [CNT_W-1:0] chg_cnt_d;
    logic [CNT_W-1:0] chg_cnt_q;
    logic             y_changed;

    nand_gate_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a (a),
        .b (b),
        .y (y)
    );

    // Next-state: load the NAND result; count changes, clear wins, never wrap
    always_comb begin
        y_q_d     = y;
        y_changed = (y_q_d != y_q);
        chg_cnt_d = chg_cnt_q;
        if (clr) begin
            chg_cnt_d = '0;
        end else if (y_changed && (chg_cnt_q != CNT_MAX)) begin
            chg_cnt_d = chg_cnt_q + 1'b1;
        end
    end

    // State registers; reset drops any pending increment immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q       <= Y_Q_RST;
            chg_cnt_q <= '0;
        end else begin
            y_q       <= y_q_d;
            chg_cnt_q <= chg_cnt_d;
        end
    end

    assign chg_cnt = chg_cnt_q;

endmodule : nand_gate
`default_nettype wire

// File: tb/tb_nand_gate.sv
`default_nettype none
// ============================================================================
// Module      : tb_nand_gate
// Description : Self-checking bench for nand_gate: a 1-bit instance with a
//               16-bit counter and an 8-bit instance with a 2-bit counter,
//               both checked against a behavioural model every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nand_gate;

    logic       clk     = 1'b0;
    logic       clk_run = 1'b0;
    logic       rst     = 1'b0;

    logic       a1 = 1'b0, b1 = 1'b0, clr1 = 1'b0;
    logic       y1, y_q1;
    logic [15:0] cnt1;

    logic [7:0] a8 = 8'h00, b8 = 8'h00;
    logic       clr8 = 1'b0;
    logic [7:0] y8, y_q8;
    logic [1:0] cnt8;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic       m1_yq;
    int         m1_cnt;
    logic [7:0] m8_yq;
    int         m8_cnt;
    bit         chk_en = 1'b0;

    nand_gate #(.WIDTH(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .clr(clr1),
        .y(y1), .y_q(y_q1), .chg_cnt(cnt1)
    );

    nand_gate #(.WIDTH(8), .CNT_W(2)) dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .clr(clr8),
        .y(y8), .y_q(y_q8), .chg_cnt(cnt8)
    );

    // Gated clock so combinational checks can run with clk idle
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: registered value is the previous NAND, counter is a
    // saturating tally of edges where it changed, clear overrides
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m1_yq  <= 1'b1;
            m1_cnt <= 0;
            m8_yq  <= 8'hFF;
            m8_cnt <= 0;
        end else begin
            m1_yq <= ~(a1 & b1);
            if (clr1)                                     m1_cnt <= 0;
            else if ((~(a1 & b1)) != m1_yq && m1_cnt < 65535) m1_cnt <= m1_cnt + 1;
            m8_yq <= ~(a8 & b8);
            if (clr8)                                     m8_cnt <= 0;
            else if ((~(a8 & b8)) != m8_yq && m8_cnt < 3) m8_cnt <= m8_cnt + 1;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("y1",    {63'd0, y1},    {63'd0, ~(a1 & b1)});
            check("y_q1",  {63'd0, y_q1},  {63'd0, m1_yq});
            check("cnt1",  {48'd0, cnt1},  64'(m1_cnt));
            check("y8",    {56'd0, y8},    {56'd0, ~(a8 & b8)});
            check("y_q8",  {56'd0, y_q8},  {56'd0, m8_yq});
            check("cnt8",  {62'd0, cnt8},  64'(m8_cnt));
        end
    end

    logic [1:0] tt_a  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0] tt_b  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       tt_y  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int         sat_exp [5] = '{1, 2, 3, 3, 3};

    initial begin
        // Power-on reset with clock idle
        #1 rst = 1'b1;
        #4 rst = 1'b0;
        #1;
        check("rst_y_q1", {63'd0, y_q1}, 64'h1);
        check("rst_cnt1", {48'd0, cnt1}, 64'h0);
        check("rst_y_q8", {56'd0, y_q8}, 64'hFF);
        check("rst_cnt8", {62'd0, cnt8}, 64'h0);

        // Truth table with clk static
        for (int i = 0; i < 5; i++) begin
            a1 = tt_a[i][0];
            b1 = tt_b[i][0];
            #0;
            #1 check("tt_y1", {63'd0, y1}, {63'd0, tt_y[i]});
            #9;
        end

        // Wide operand combinational check
        a8 = 8'hF0; b8 = 8'hCC;
        #1 check("wide_y8", {56'd0, y8}, 64'h3F);

        // Randomized traffic with occasional asynchronous reset pulses
        clk_run = 1'b1;
        chk_en  = 1'b1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            #2;
            a1   = 1'($urandom);
            b1   = 1'($urandom);
            clr1 = ($urandom_range(0, 9) == 0);
            a8   = 8'($urandom);
            b8   = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
            clr8 = ($urandom_range(0, 15) == 0);
            rst  = ($urandom_range(0, 39) == 0);
        end

        // Mid-operation asynchronous reset between edges
        @(negedge clk);
        #2;
        rst = 1'b0; clr1 = 1'b0; clr8 = 1'b0;
        a1 = 1'b1; b1 = 1'b0; a8 = 8'hFF; b8 = 8'h0F;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_y_q1", {63'd0, y_q1}, 64'h1);
        check("async_cnt1", {48'd0, cnt1}, 64'h0);
        check("async_y_q8", {56'd0, y_q8}, 64'hFF);
        check("async_cnt8", {62'd0, cnt8}, 64'h0);
        check("async_y8",   {56'd0, y8},   64'hF0);

        // Latency and count
        @(negedge clk);
        #2;
        rst = 1'b0; a1 = 1'b1; b1 = 1'b1; a8 = 8'h00; b8 = 8'h00;
        #1 check("lat_y1", {63'd0, y1}, 64'h0);
        check("lat_y_q1_pre", {63'd0, y_q1}, 64'h1);
        @(negedge clk);
        #1;
        check("lat_y_q1_e1", {63'd0, y_q1}, 64'h0);
        check("lat_cnt1_e1", {48'd0, cnt1}, 64'h1);
        #1 a1 = 1'b0;
        @(negedge clk);
        #1;
        check("lat_y_q1_e2", {63'd0, y_q1}, 64'h1);
        check("lat_cnt1_e2", {48'd0, cnt1}, 64'h2);

        // Saturation on the 2-bit counter
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a8 = (i % 2 == 0) ? 8'hFF : 8'h00;
            b8 = 8'hFF;
            @(negedge clk);
            #1 check("sat_cnt8", {62'd0, cnt8}, 64'(sat_exp[i]));
            #1;
        end

        // Clear priority over a simultaneous change
        a1 = 1'b1; b1 = 1'b1; clr1 = 1'b1;
        @(negedge clk);
        #1;
        check("clr_y_q1", {63'd0, y_q1}, 64'h0);
        check("clr_cnt1", {48'd0, cnt1}, 64'h0);
        #1 clr1 = 1'b0; a1 = 1'b0;
        @(negedge clk);
        #1 check("clr_cnt1_next", {48'd0, cnt1}, 64'h1);

        // Wide operand registered one edge later
        #1 a8 = 8'hF0; b8 = 8'hCC;
        #1 check("wide_y8_b", {56'd0, y8}, 64'h3F);
        @(negedge clk);
        #1 check("wide_y_q8", {56'd0, y_q8}, 64'h3F);

        chk_en = 1'b0;
        clk_run = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_nand_gate
`default_nettype wire
